// File: rtl/rocket_sim_mem_if.sv
// rocket_sim_mem_if: request/response bundle between the AXI-to-memory adapter (master) and the simulation SRAM (slave).
//   req_i/we_i/addr_i/be_i/data_i : request stream, one per cycle, no back-pressure
//   data_o                        : registered read data, 1-cycle latency
//   tohost_valid_o/tohost_data_o  : tohost snoop
//   oob_err_o/oob_addr_o          : sticky out-of-range flag and first offending address
interface rocket_sim_mem_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  logic                        req_i;
  logic                        we_i;
  logic [AXI_ADDR_WIDTH-1:0]   addr_i;
  logic [AXI_DATA_WIDTH/8-1:0] be_i;
  logic [AXI_DATA_WIDTH-1:0]   data_i;
  logic [AXI_DATA_WIDTH-1:0]   data_o;
  logic                        tohost_valid_o;
  logic [AXI_DATA_WIDTH-1:0]   tohost_data_o;
  logic                        oob_err_o;
  logic [AXI_ADDR_WIDTH-1:0]   oob_addr_o;
  modport master (
    output req_i, we_i, addr_i, be_i, data_i,
    input  data_o, tohost_valid_o, tohost_data_o, oob_err_o, oob_addr_o
  );
  modport slave (
    input  req_i, we_i, addr_i, be_i, data_i,
    output data_o, tohost_valid_o, tohost_data_o, oob_err_o, oob_addr_o
  );
endinterface

// File: rtl/rocket_sim_mem.sv
// rocket_sim_mem: word-addressed simulation SRAM with 1-cycle read latency, tohost snoop and sticky out-of-range flag.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (outputs only; the array is never reset)
//   bus    : slave side of rocket_sim_mem_if (request stream in, read data and status out)
module rocket_sim_mem #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = 32'h8000_0000,
  parameter int                        MEM_WORDS      = 65536,
  parameter logic [AXI_ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter string                     INIT_FILE      = ""
) (
  input logic               clk_i,
  input logic               rst_ni,
  rocket_sim_mem_if.slave   bus
);
  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int NB  = DW / 8;
  localparam int LNB = $clog2(NB);
  localparam int IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW:0] WORDS_W = (AW + 1)'(MEM_WORDS);
  localparam logic [AW:0] TH_OFF  = {1'b0, TOHOST_ADDR} - {1'b0, MEM_BASE};

  logic [DW-1:0] r_mem [MEM_WORDS];
  logic [DW-1:0] r_data;
  logic          r_th_valid;
  logic [DW-1:0] r_th_data;
  logic          r_oob;
  logic [AW-1:0] r_oob_addr;

  logic [AW:0]   w_off;
  logic [AW:0]   w_word;
  logic          w_in;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_old;
  logic [DW-1:0] w_merged;
  logic          w_wr;
  logic          w_th_hit;

  // One extra bit keeps addresses below MEM_BASE from wrapping into range.
  assign w_off  = {1'b0, bus.addr_i} - {1'b0, MEM_BASE};
  assign w_word = w_off >> LNB;
  assign w_in   = !w_off[AW] && (w_word < WORDS_W);
  assign w_idx  = w_word[IW-1:0];

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign w_mask[8*b +: 8] = {8{bus.be_i[b]}};
  end

  assign w_old    = r_mem[w_idx];
  assign w_merged = (bus.data_i & w_mask) | (w_old & ~w_mask);
  assign w_wr     = rst_ni && bus.req_i && bus.we_i && w_in;
  // Zero-valued (after masking) writes are the host clearing tohost and must not raise the flag.
  assign w_th_hit = w_wr && (bus.addr_i[AW-1:LNB] == TOHOST_ADDR[AW-1:LNB]) && |(bus.data_i & w_mask);

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data     <= '0;
      r_th_valid <= 1'b0;
      r_th_data  <= '0;
      r_oob      <= 1'b0;
      r_oob_addr <= '0;
    end else if (bus.req_i) begin
      if (!w_in) begin
        if (!bus.we_i) r_data <= '0;
        r_oob <= 1'b1;
        if (!r_oob) r_oob_addr <= bus.addr_i;
      end else if (!bus.we_i) begin
        r_data <= w_old;
      end else if (w_th_hit) begin
        r_th_valid <= 1'b1;
        r_th_data  <= w_merged;
      end
    end
  end

  assign bus.data_o         = r_data;
  assign bus.tohost_valid_o = r_th_valid;
  assign bus.tohost_data_o  = r_th_data;
  assign bus.oob_err_o      = r_oob;
  assign bus.oob_addr_o     = r_oob_addr;

  initial begin
    assert (MEM_WORDS > 0) else $error("rocket_sim_mem: MEM_WORDS must be non-zero");
    assert (DW >= 8 && (DW & (DW - 1)) == 0) else $error("rocket_sim_mem: AXI_DATA_WIDTH must be a power of two >= 8");
    assert (!TH_OFF[AW] && (TH_OFF >> LNB) < WORDS_W) else $error("rocket_sim_mem: TOHOST_ADDR outside the array");
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown({bus.req_i, bus.we_i}))
    else $warning("rocket_sim_mem: X on req_i/we_i");
endmodule

// File: tb/tb_rocket_sim_mem.sv
// tb_rocket_sim_mem: directed self-checking bench for rocket_sim_mem.
module tb_rocket_sim_mem;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_pass   = 0;

  rocket_sim_mem_if bus ();

  rocket_sim_mem dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic xfer(input logic we, input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
    bus.req_i  = 1'b1;
    bus.we_i   = we;
    bus.addr_i = a;
    bus.be_i   = be;
    bus.data_i = d;
    @(posedge clk_i);
    #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, bus.data_o, 64'h0);
    check({tag, "_thv"}, {63'h0, bus.tohost_valid_o}, 64'h0);
    check({tag, "_thd"}, bus.tohost_data_o, 64'h0);
    check({tag, "_oob"}, {63'h0, bus.oob_err_o}, 64'h0);
    check({tag, "_oobaddr"}, {32'h0, bus.oob_addr_o}, 64'h0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
    bus.be_i   = '0;
    bus.data_i = '0;
    idle(3);
    check_reset_outputs("rst");
    rst_ni = 1'b1;
    idle(1);
    // basic write/read, 1-cycle latency, hold on idle
    xfer(1, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
    check("wr_holds", bus.data_o, 64'h0);
    xfer(0, 32'h8000_0010, 8'h00, 64'h0);
    check("rd_lat1", bus.data_o, 64'h1122_3344_5566_7788);
    idle(2);
    check("rd_hold", bus.data_o, 64'h1122_3344_5566_7788);
    // byte enables on word 0x10
    xfer(1, 32'h8000_0080, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    xfer(1, 32'h8000_0080, 8'h0F, 64'h0);
    xfer(0, 32'h8000_0080, 8'h00, 64'h0);
    check("be_0f", bus.data_o, 64'hFFFF_FFFF_0000_0000);
    xfer(1, 32'h8000_0084, 8'h00, 64'h0);
    xfer(0, 32'h8000_0087, 8'h00, 64'h0);
    check("be_00", bus.data_o, 64'hFFFF_FFFF_0000_0000);
    // read-after-write in consecutive cycles
    xfer(1, 32'h8000_0020, 8'hFF, 64'hAAAA);
    xfer(0, 32'h8000_0020, 8'h00, 64'h0);
    check("raw", bus.data_o, 64'hAAAA);
    // back-to-back reads
    xfer(1, 32'h8000_0000, 8'hFF, 64'h0101_0101_0101_0101);
    xfer(1, 32'h8000_0008, 8'hFF, 64'h0202_0202_0202_0202);
    xfer(0, 32'h8000_0000, 8'h00, 64'h0);
    check("b2b_w0", bus.data_o, 64'h0101_0101_0101_0101);
    xfer(0, 32'h8000_0008, 8'h00, 64'h0);
    check("b2b_w1", bus.data_o, 64'h0202_0202_0202_0202);
    // last in-range word
    xfer(1, 32'h8007_FFF8, 8'hFF, 64'h5A5A_0000_1234_5678);
    xfer(0, 32'h8007_FFF8, 8'h00, 64'h0);
    check("last_word", bus.data_o, 64'h5A5A_0000_1234_5678);
    check("last_no_oob", {63'h0, bus.oob_err_o}, 64'h0);
    // out of range below base, then one word past the end
    xfer(0, 32'h7FFF_FFF8, 8'h00, 64'h0);
    check("oob_rd_data", bus.data_o, 64'h0);
    check("oob_err", {63'h0, bus.oob_err_o}, 64'h1);
    check("oob_addr1", {32'h0, bus.oob_addr_o}, {32'h0, 32'h7FFF_FFF8});
    xfer(1, 32'h8008_0000, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
    check("oob_addr2", {32'h0, bus.oob_addr_o}, {32'h0, 32'h7FFF_FFF8});
    xfer(0, 32'h8000_0000, 8'h00, 64'h0);
    check("oob_no_alias", bus.data_o, 64'h0101_0101_0101_0101);
    check("oob_sticky", {63'h0, bus.oob_err_o}, 64'h1);
    // tohost snoop
    xfer(1, 32'h8000_1000, 8'hFF, 64'h0);
    check("th_zero", {63'h0, bus.tohost_valid_o}, 64'h0);
    xfer(1, 32'h8000_1000, 8'hFE, 64'h0000_0000_0000_0001);
    check("th_masked0", {63'h0, bus.tohost_valid_o}, 64'h0);
    xfer(1, 32'h8000_1000, 8'h01, 64'hFFFF_FFFF_FFFF_FF01);
    check("th_valid", {63'h0, bus.tohost_valid_o}, 64'h1);
    check("th_data", bus.tohost_data_o, 64'h1);
    xfer(1, 32'h8000_1000, 8'hFF, 64'h0);
    check("th_clr_v", {63'h0, bus.tohost_valid_o}, 64'h1);
    check("th_clr_d", bus.tohost_data_o, 64'h1);
    xfer(0, 32'h8000_1000, 8'h00, 64'h0);
    check("th_array", bus.data_o, 64'h0);
    // reset mid-burst: outputs clear, array survives, request under reset ignored
    xfer(1, 32'h8000_0100, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    xfer(0, 32'h8000_0100, 8'h00, 64'h0);
    check("pre_rst", bus.data_o, 64'hDEAD_BEEF_CAFE_F00D);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = 32'h8000_0100;
    bus.be_i   = 8'hFF;
    bus.data_i = 64'h0;
    rst_ni     = 1'b0;
    #1;
    check_reset_outputs("arst");
    idle(2);
    check_reset_outputs("rst2");
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    rst_ni    = 1'b1;
    idle(1);
    xfer(0, 32'h8000_0100, 8'h00, 64'h0);
    check("post_rst", bus.data_o, 64'hDEAD_BEEF_CAFE_F00D);
    xfer(0, 32'h8000_0010, 8'h00, 64'h0);
    check("post_rst2", bus.data_o, 64'h1122_3344_5566_7788);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
